// File: rtl/servo_pkg.sv
// Shared constants, helper functions and FSM state type for the multi-channel servo PWM block.
package servo_pkg;

   typedef enum logic [0:0] {RUN, UPDATE} state_e;

   function automatic int unsigned period_cyc(int unsigned clk_hz, int unsigned pwm_hz);
      return clk_hz / pwm_hz;
   endfunction

   function automatic int unsigned center_cyc(int unsigned clk_hz, int unsigned min_us,
                                              int unsigned max_us);
      return (clk_hz / 1_000_000) * (min_us + max_us) / 2;
   endfunction

   // Truncated cycles per degree over the full -90..+90 span
   function automatic int unsigned cyc_per_deg(int unsigned clk_hz, int unsigned min_us,
                                               int unsigned max_us);
      return (clk_hz / 1_000_000) * (max_us - min_us) / 180;
   endfunction

   function automatic int clamp_angle(int ang, int lim);
      if (ang > lim)  return lim;
      if (ang < -lim) return -lim;
      return ang;
   endfunction

   function automatic int pulse_cyc(int ang, int center, int per_deg);
      return center + ang * per_deg;
   endfunction

   localparam int unsigned PERIOD_CYC  = period_cyc(100_000_000, 50);
   localparam int unsigned CENTER_CYC  = center_cyc(100_000_000, 1000, 2000);
   localparam int unsigned CYC_PER_DEG = cyc_per_deg(100_000_000, 1000, 2000);
   localparam int unsigned PW_W_DEF    = $clog2(PERIOD_CYC);

endpackage

// File: rtl/servo_slew_step.sv
// One slew step toward target plus pulse width of the new angle; shared across channels.
module servo_slew_step
   import servo_pkg::*;
#(
   parameter int unsigned ANGLE_W     = 8,
   parameter int unsigned SLEW_DEG    = 5,
   parameter int unsigned CENTER_CYC  = servo_pkg::CENTER_CYC,
   parameter int unsigned CYC_PER_DEG = servo_pkg::CYC_PER_DEG,
   parameter int unsigned PW_W        = servo_pkg::PW_W_DEF
) (
   input  logic signed [ANGLE_W-1:0] target_i,
   input  logic signed [ANGLE_W-1:0] current_i,
   output logic signed [ANGLE_W-1:0] cur_next_o,
   output logic        [PW_W-1:0]    pulse_o
);

   localparam logic signed [ANGLE_W:0] SLEW = (ANGLE_W+1)'(SLEW_DEG);

   logic signed [ANGLE_W:0] diff_w;
   logic signed [ANGLE_W:0] step_w;

   always_comb begin
      diff_w = {target_i[ANGLE_W-1], target_i} - {current_i[ANGLE_W-1], current_i};
      step_w = {target_i[ANGLE_W-1], target_i};
      if (SLEW_DEG != 0) begin
         if (diff_w > SLEW)
            step_w = {current_i[ANGLE_W-1], current_i} + SLEW;
         else if (diff_w < -SLEW)
            step_w = {current_i[ANGLE_W-1], current_i} - SLEW;
      end
      cur_next_o = step_w[ANGLE_W-1:0];
      pulse_o    = PW_W'(pulse_cyc(int'(cur_next_o), int'(CENTER_CYC), int'(CYC_PER_DEG)));
   end

endmodule

// File: rtl/servo_pwm_multich.sv
// Multi-channel servo PWM: clamped/slew-limited angle commands, widths swapped at frame wrap.
module servo_pwm_multich
   import servo_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
   parameter int unsigned PWM_FREQ_HZ  = 50,
   parameter int unsigned NUM_CH       = 2,
   parameter int unsigned ANGLE_W      = 8,
   parameter int unsigned ANGLE_LIMIT  = 60,
   parameter int unsigned SLEW_DEG     = 5,
   parameter int unsigned MIN_PULSE_US = 1000,
   parameter int unsigned MAX_PULSE_US = 2000,
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [CH_W-1:0]           cmd_ch,
   input  logic signed [ANGLE_W-1:0] cmd_angle,
   output logic                      cmd_clamped,
   output logic                      cmd_err,
   output logic [NUM_CH-1:0]         pwm_out,
   output logic [NUM_CH-1:0]         at_target,
   output logic                      frame_start
);

   localparam int unsigned PER_CYC   = period_cyc(CLK_FREQ_HZ, PWM_FREQ_HZ);
   localparam int unsigned CTR_CYC   = center_cyc(CLK_FREQ_HZ, MIN_PULSE_US, MAX_PULSE_US);
   localparam int unsigned DEG_CYC   = cyc_per_deg(CLK_FREQ_HZ, MIN_PULSE_US, MAX_PULSE_US);
   localparam int unsigned CNT_W     = $clog2(PER_CYC);
   localparam int unsigned PW_W      = CNT_W;
   localparam int unsigned UPD_START = PER_CYC - NUM_CH;

   state_e                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic signed [ANGLE_W-1:0] tgt_q [NUM_CH];
   logic signed [ANGLE_W-1:0] tgt_d [NUM_CH];
   logic signed [ANGLE_W-1:0] cur_q [NUM_CH];
   logic signed [ANGLE_W-1:0] cur_d [NUM_CH];
   logic [PW_W-1:0]           shd_q [NUM_CH];
   logic [PW_W-1:0]           shd_d [NUM_CH];
   logic [PW_W-1:0]           act_q [NUM_CH];
   logic [PW_W-1:0]           act_d [NUM_CH];
   logic                      ready_q, ready_d;
   logic                      clamped_q, clamped_d;
   logic                      err_q, err_d;
   logic                      frame_q, frame_d;
   logic [NUM_CH-1:0]         pwm_q, pwm_d;
   logic [NUM_CH-1:0]         at_q, at_d;

   logic                      wrap_w;
   logic                      accept_w;
   logic [CH_W-1:0]           upd_idx_w;
   logic signed [ANGLE_W-1:0] stp_cur_w;
   logic [PW_W-1:0]           stp_pw_w;
   int                        clamp_w;

   assign wrap_w    = (cnt_q == CNT_W'(PER_CYC - 1));
   assign accept_w  = cmd_valid && ready_q;
   assign clamp_w   = clamp_angle(int'(cmd_angle), int'(ANGLE_LIMIT));
   // Channel k is serviced on the k-th cycle of the UPDATE window
   assign upd_idx_w = (state_q == UPDATE) ? CH_W'(cnt_q - CNT_W'(UPD_START)) : '0;

   servo_slew_step #(
      .ANGLE_W     (ANGLE_W),
      .SLEW_DEG    (SLEW_DEG),
      .CENTER_CYC  (CTR_CYC),
      .CYC_PER_DEG (DEG_CYC),
      .PW_W        (PW_W)
   ) u_step (
      .target_i   (tgt_q[upd_idx_w]),
      .current_i  (cur_q[upd_idx_w]),
      .cur_next_o (stp_cur_w),
      .pulse_o    (stp_pw_w)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = wrap_w ? '0 : cnt_q + 1'b1;
      tgt_d     = tgt_q;
      cur_d     = cur_q;
      shd_d     = shd_q;
      act_d     = act_q;
      clamped_d = 1'b0;
      err_d     = 1'b0;

      if (accept_w) begin
         if ({1'b0, cmd_ch} >= (CH_W+1)'(NUM_CH)) begin
            err_d = 1'b1;
         end else begin
            tgt_d[cmd_ch] = ANGLE_W'(clamp_w);
            clamped_d     = (clamp_w != int'(cmd_angle));
         end
      end

      case (state_q)
         RUN: begin
            if (cnt_q == CNT_W'(UPD_START - 1)) state_d = UPDATE;
         end
         UPDATE: begin
            cur_d[upd_idx_w] = stp_cur_w;
            shd_d[upd_idx_w] = stp_pw_w;
            if (wrap_w) state_d = RUN;
         end
         default: state_d = RUN;
      endcase

      // Shadow includes the last channel's update written on this same edge
      if (wrap_w) act_d = shd_d;

      ready_d = (state_d == RUN);
      frame_d = (cnt_q == '0);
      for (int k = 0; k < int'(NUM_CH); k++) begin
         pwm_d[k] = (cnt_q < act_q[k]);
         at_d[k]  = (cur_q[k] == tgt_q[k]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RUN;
         cnt_q     <= '0;
         ready_q   <= 1'b1;
         clamped_q <= 1'b0;
         err_q     <= 1'b0;
         frame_q   <= 1'b0;
         pwm_q     <= '0;
         at_q      <= '1;
         for (int k = 0; k < int'(NUM_CH); k++) begin
            tgt_q[k] <= '0;
            cur_q[k] <= '0;
            shd_q[k] <= PW_W'(CTR_CYC);
            act_q[k] <= PW_W'(CTR_CYC);
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tgt_q     <= tgt_d;
         cur_q     <= cur_d;
         shd_q     <= shd_d;
         act_q     <= act_d;
         ready_q   <= ready_d;
         clamped_q <= clamped_d;
         err_q     <= err_d;
         frame_q   <= frame_d;
         pwm_q     <= pwm_d;
         at_q      <= at_d;
      end
   end

   assign cmd_ready   = ready_q;
   assign cmd_clamped = clamped_q;
   assign cmd_err     = err_q;
   assign frame_start = frame_q;
   assign pwm_out     = pwm_q;
   assign at_target   = at_q;

endmodule

// File: tb/tb_servo_pwm_multich.sv
// Bench for servo_pwm_multich: frame-level reference model, per-cycle compare, literal pulse-width pins.
module tb_servo_pwm_multich;

   localparam int CLK_HZ = 1_000_000;
   localparam int PWM_HZ = 500;
   localparam int NCH    = 3;
   localparam int LIM    = 60;
   localparam int SLEW   = 5;
   localparam int MIN_US = 1000;
   localparam int MAX_US = 2000;
   localparam int P      = CLK_HZ / PWM_HZ;
   localparam int CENTER = (CLK_HZ / 1_000_000) * (MIN_US + MAX_US) / 2;
   localparam int PDEG   = (CLK_HZ / 1_000_000) * (MAX_US - MIN_US) / 180;
   localparam int UPD    = P - NCH;

   logic              clk;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_ch;
   logic signed [7:0] cmd_angle;
   logic              cmd_clamped;
   logic              cmd_err;
   logic [NCH-1:0]    pwm_out;
   logic [NCH-1:0]    at_target;
   logic              frame_start;

   servo_pwm_multich #(
      .CLK_FREQ_HZ  (CLK_HZ),
      .PWM_FREQ_HZ  (PWM_HZ),
      .NUM_CH       (NCH),
      .ANGLE_W      (8),
      .ANGLE_LIMIT  (LIM),
      .SLEW_DEG     (SLEW),
      .MIN_PULSE_US (MIN_US),
      .MAX_PULSE_US (MAX_US)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_ch      (cmd_ch),
      .cmd_angle   (cmd_angle),
      .cmd_clamped (cmd_clamped),
      .cmd_err     (cmd_err),
      .pwm_out     (pwm_out),
      .at_target   (at_target),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: time-indexed frame counter, per-channel target/angle, frame pulse widths
   int           m_cnt;
   int           m_tgt [NCH];
   int           m_cur [NCH];
   int           m_w   [NCH];
   bit           e_ready, e_clamped, e_err, e_frame;
   bit [NCH-1:0] e_pwm, e_at;
   bit           mv_acc;
   int           mv_ang, mv_clp, mv_slot, mv_d;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_cnt = 0;
         for (int k = 0; k < NCH; k++) begin
            m_tgt[k] = 0; m_cur[k] = 0; m_w[k] = CENTER;
         end
         e_ready = 1; e_clamped = 0; e_err = 0; e_frame = 0; e_pwm = '0; e_at = '1;
      end else begin
         mv_acc = cmd_valid && e_ready;
         mv_ang = int'(cmd_angle);
         mv_clp = (mv_ang > LIM) ? LIM : ((mv_ang < -LIM) ? -LIM : mv_ang);
         e_err     = mv_acc && (int'(cmd_ch) >= NCH);
         e_clamped = mv_acc && (int'(cmd_ch) < NCH) && (mv_clp != mv_ang);
         e_frame   = (m_cnt == 0);
         for (int k = 0; k < NCH; k++) begin
            e_pwm[k] = (m_cnt < m_w[k]);
            e_at[k]  = (m_cur[k] == m_tgt[k]);
         end
         mv_slot = m_cnt - UPD;
         if (mv_slot >= 0 && mv_slot < NCH) begin
            mv_d = m_tgt[mv_slot] - m_cur[mv_slot];
            if (mv_d > SLEW)       m_cur[mv_slot] = m_cur[mv_slot] + SLEW;
            else if (mv_d < -SLEW) m_cur[mv_slot] = m_cur[mv_slot] - SLEW;
            else                   m_cur[mv_slot] = m_tgt[mv_slot];
         end
         if (mv_acc && int'(cmd_ch) < NCH) m_tgt[cmd_ch] = mv_clp;
         if (m_cnt == P - 1) begin
            for (int k = 0; k < NCH; k++) m_w[k] = CENTER + m_cur[k] * PDEG;
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
         e_ready = (m_cnt < UPD);
      end
   end

   initial forever begin
      @(negedge clk);
      check("cmd_ready",   int'(cmd_ready),   int'(e_ready));
      check("cmd_clamped", int'(cmd_clamped), int'(e_clamped));
      check("cmd_err",     int'(cmd_err),     int'(e_err));
      check("frame_start", int'(frame_start), int'(e_frame));
      check("pwm_out",     int'(pwm_out),     int'(e_pwm));
      check("at_target",   int'(at_target),   int'(e_at));
   end

   // High-time of each channel over the frame that just ended
   int hi [NCH];
   int last_w [NCH];
   initial forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
         for (int k = 0; k < NCH; k++) begin hi[k] = 0; last_w[k] = 0; end
      end else if (frame_start) begin
         for (int k = 0; k < NCH; k++) begin last_w[k] = hi[k]; hi[k] = int'(pwm_out[k]); end
      end else begin
         for (int k = 0; k < NCH; k++) hi[k] = hi[k] + int'(pwm_out[k]);
      end
   end

   task automatic wait_frame();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_start && n < 3 * P);
      if (!frame_start) check("frame_timeout", 0, 1);
      #1;
   endtask

   task automatic send(input int ch, input int ang, output bit cl, output bit er);
      int n;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_ch    = 2'(ch);
      cmd_angle = 8'(ang);
      n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) check("send_timeout", 0, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      cl = cmd_clamped;
      er = cmd_err;
   endtask

   int exp_w [4] = '{1525, 1550, 1575, 1600};
   bit cl, er;
   int low;

   initial begin
      #(950_000);
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_valid = 1'b0;
      cmd_ch    = '0;
      cmd_angle = '0;
      rst       = 1'b0;
      #1 rst    = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_pwm",   int'(pwm_out),     0);
      check("rst_ready", int'(cmd_ready),   1);
      check("rst_at",    int'(at_target),   7);
      check("rst_frame", int'(frame_start), 0);
      rst = 1'b0;

      wait_frame();
      wait_frame();
      for (int k = 0; k < NCH; k++) check("center_width", last_w[k], 1500);
      check("center_at", int'(at_target), 7);

      send(0, 20, cl, er);
      check("ch0_no_clamp", int'(cl), 0);
      send(1, -100, cl, er);
      check("ch1_clamp_pulse", int'(cl), 1);
      check("ch1_no_err", int'(er), 0);
      send(2, 45, cl, er);
      check("ch2_no_clamp", int'(cl), 0);

      wait_frame();
      for (int i = 0; i < 4; i++) begin
         wait_frame();
         check("ch0_slew_width", last_w[0], exp_w[i]);
      end
      check("ch0_at_target", int'(at_target[0]), 1);
      check("ch1_moving", int'(at_target[1]), 0);

      repeat (8) wait_frame();
      check("ch1_settled_width", last_w[1], 1200);
      check("ch2_settled_width", last_w[2], 1725);
      check("ch0_hold_width",    last_w[0], 1600);
      check("all_at_target", int'(at_target), 7);

      // Command held across the UPDATE window, aimed at a nonexistent channel
      low = 0;
      while (cmd_ready && low < 3 * P) begin
         @(negedge clk);
         low++;
      end
      cmd_valid = 1'b1;
      cmd_ch    = 2'd3;
      cmd_angle = 8'sd10;
      low = 1;
      @(negedge clk);
      while (!cmd_ready && low < 100) begin
         low++;
         @(negedge clk);
      end
      check("update_window_len", low, NCH);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("err_pulse",     int'(cmd_err),     1);
      check("err_first_run", int'(frame_start), 1);
      check("err_no_clamp",  int'(cmd_clamped), 0);

      repeat (16000) begin
         @(negedge clk);
         cmd_valid = ($urandom_range(0, 7) == 0);
         cmd_ch    = 2'($urandom_range(0, 3));
         cmd_angle = 8'($urandom);
      end
      @(negedge clk);
      cmd_valid = 1'b0;

      wait_frame();
      repeat (10) @(negedge clk);
      check("pre_rst_high", int'(pwm_out), 7);
      #2 rst = 1'b1;
      #1;
      check("midrst_pwm",   int'(pwm_out),   0);
      check("midrst_at",    int'(at_target), 7);
      check("midrst_ready", int'(cmd_ready), 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_frame();
      wait_frame();
      for (int k = 0; k < NCH; k++) check("post_rst_width", last_w[k], 1500);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/servo_pwm_multich.md
# servo_pwm_multich

Parametrised multi-channel successor to the pan/tilt proportional PWM controller. Accepts per-channel signed angle commands through a valid/ready port, clamps them to a mechanical limit, slew-limits each channel once per PWM period, and drives NUM_CH glitch-free 50 Hz servo PWM outputs. It sits between the coordinate-to-angle stage and the servo pins.

## Interface
- CLK_FREQ_HZ, 100_000_000, system clock frequency
- PWM_FREQ_HZ, 50, servo frame rate; PERIOD_CYC = CLK_FREQ_HZ/PWM_FREQ_HZ (2_000_000)
- NUM_CH, 2, servo channels (1..16)
- ANGLE_W, 8, signed angle width in degrees
- ANGLE_LIMIT, 60, clamp magnitude in degrees
- SLEW_DEG, 5, max change per period per channel in degrees; 0 = unlimited
- MIN_PULSE_US, 1000, pulse at -90°; MAX_PULSE_US, 2000, pulse at +90°

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid & ready
- cmd_ch  in  $clog2(NUM_CH) (min 1)  target channel
- cmd_angle  in  ANGLE_W signed  requested angle, degrees
- cmd_clamped  out  1  one-cycle pulse: accepted angle was clamped
- cmd_err  out  1  one-cycle pulse: accepted cmd_ch ≥ NUM_CH (command dropped)
- pwm_out  out  NUM_CH  servo PWM, one bit per channel
- at_target  out  NUM_CH  current angle equals target
- frame_start  out  1  one-cycle pulse at period counter == 0

## Operation
- Derived: CYC_PER_US = CLK_FREQ_HZ/1_000_000; CENTER_CYC = CYC_PER_US·(MIN+MAX)/2 (150000); CYC_PER_DEG = CYC_PER_US·(MAX−MIN)/180, truncated (555).
- Per channel: target, current (ANGLE_W signed), shadow and active pulse widths (≥ $clog2(PERIOD_CYC) bits).
- Accept: target[cmd_ch] ← clamp(cmd_angle, ±ANGLE_LIMIT); cmd_clamped pulses if clamping changed the value. Multiple accepts to one channel in a period: last wins.
- States: RUN → UPDATE when counter == PERIOD_CYC−NUM_CH−1; UPDATE holds NUM_CH cycles, processing channel k on the k-th cycle; → RUN at wrap.
- UPDATE step k: d = target−current; if SLEW_DEG==0 or |d| ≤ SLEW_DEG, current ← target, else current ± SLEW_DEG. shadow[k] ← CENTER_CYC + current_new·CYC_PER_DEG (signed multiply, result always positive). One shared multiplier.
- At wrap (counter PERIOD_CYC−1 → 0): active ← shadow for all channels simultaneously; widths never change mid-period.
- pwm_out[k] = (counter < active[k]), registered.
- at_target[k] = (current[k] == target[k]), registered.

## Timing
- Reset values: counter 0, state RUN, target = current = 0, shadow = active = CENTER_CYC, cmd_ready 1, cmd_clamped/cmd_err/frame_start 0, pwm_out 0, at_target all 1.
- First cycle after reset release: counter 0; pwm_out all 1 from the next edge, producing center pulses.
- cmd_ready = 0 during UPDATE (last NUM_CH cycles of each period), 1 otherwise; commands presented during UPDATE wait.
- Latency: command accepted in period P before UPDATE → new pulse (one slew step) visible in period P+1; full move of Δ degrees takes ceil(|Δ|/SLEW_DEG) periods.
- cmd_clamped/cmd_err asserted the cycle after acceptance.
- Reset mid-period: all outputs drop to their reset values immediately, even mid-pulse.

## Structure
- Package servo_pkg: derived constants (PERIOD_CYC, CENTER_CYC, CYC_PER_DEG), clamp and pulse-width functions, state enum {RUN, UPDATE}.
- Sub-module servo_slew_step: combinational slew and pulse-width computation for one channel, instantiated once and time-multiplexed over channels during UPDATE.

## Test plan
- Reset, no commands → every pwm_out high 150000 cycles per 2_000_000-cycle frame; at_target all 1.
- SLEW_DEG=0, ch0 ← +45 → next frame ch0 pulse 150000+45·555 = 174975; ch1 stays 150000.
- ch1 ← −100 → cmd_clamped pulse; ch1 settles to −60, pulse 116700.
- SLEW_DEG=5, ch0 0→+20 → pulses 152775, 155550, 158325, 161100 over four frames; at_target[0] rises with the fourth.
- Command held valid into the UPDATE window → cmd_ready low NUM_CH cycles, accepted on the first RUN cycle; cmd_ch=NUM_CH → cmd_err pulse, no state change.
- Assert rst mid-pulse → pwm_out low immediately; after release, center pulses resume from counter 0.
